// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, variable-latency imem handshake,
// one-entry skid buffer for stalls and the IF/ID pipeline register.
//
// state | meaning
// ------+-----------------------------------------------------------------
// REQ   | request presented at r_ReqAddr, waiting for (or taking) an ack
// DROP  | redirect pending; in-flight fetch is finished and its data thrown away
// HOLD  | fetched instruction parked in skid buffer while decode is stalled
module fetch_stage #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int INSTR_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                     i_CLK,
    input  logic                     i_RST,
    input  logic                     i_StallF,
    input  logic                     i_FlushD,
    input  logic                     i_PCSrcD,
    input  logic [ADDRESS_WIDTH-1:0] i_PCNextD,
    output logic                     o_IMemReq,
    output logic [ADDRESS_WIDTH-1:0] o_IMemAddr,
    input  logic                     i_IMemAck,
    input  logic [INSTR_WIDTH-1:0]   i_IMemRdata,
    output logic [ADDRESS_WIDTH-1:0] o_PCF,
    output logic [INSTR_WIDTH-1:0]   o_InstrD,
    output logic [ADDRESS_WIDTH-1:0] o_PCPlus4D,
    output logic                     o_ValidD,
    output logic                     o_FetchWait
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_DROP = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] PC_STEP    = ADDRESS_WIDTH'(4);
    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ~ADDRESS_WIDTH'(3);

    state_t                   state;
    logic [ADDRESS_WIDTH-1:0] r_ReqAddr;
    logic [ADDRESS_WIDTH-1:0] r_Redirect;
    logic [INSTR_WIDTH-1:0]   skid_instr;
    logic [ADDRESS_WIDTH-1:0] skid_pc4;
    logic [INSTR_WIDTH-1:0]   instr_d;
    logic [ADDRESS_WIDTH-1:0] pc4_d;
    logic                     valid_d;

    logic                     redirect;
    logic [ADDRESS_WIDTH-1:0] target;
    logic [ADDRESS_WIDTH-1:0] pc_plus4;

    assign redirect = i_PCSrcD & ~i_StallF;
    assign target   = i_PCNextD & ALIGN_MASK;
    assign pc_plus4 = r_ReqAddr + PC_STEP;

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            state      <= ST_REQ;
            r_ReqAddr  <= RESET_PC;
            r_Redirect <= '0;
            skid_instr <= '0;
            skid_pc4   <= '0;
            instr_d    <= '0;
            pc4_d      <= '0;
            valid_d    <= 1'b0;
        end else begin
            case (state)
                ST_REQ: begin
                    if (i_IMemAck && redirect) begin
                        r_ReqAddr <= target;
                        instr_d   <= '0;
                        valid_d   <= 1'b0;
                    end else if (redirect) begin
                        r_Redirect <= target;
                        state      <= ST_DROP;
                        instr_d    <= '0;
                        valid_d    <= 1'b0;
                    end else if (i_IMemAck && !i_StallF) begin
                        instr_d   <= i_IMemRdata;
                        pc4_d     <= pc_plus4;
                        valid_d   <= 1'b1;
                        r_ReqAddr <= pc_plus4;
                    end else if (i_IMemAck) begin
                        skid_instr <= i_IMemRdata;
                        skid_pc4   <= pc_plus4;
                        r_ReqAddr  <= pc_plus4;
                        state      <= ST_HOLD;
                    end else if (!i_StallF) begin
                        instr_d <= '0;
                        valid_d <= 1'b0;
                    end
                end
                ST_DROP: begin
                    // The old request must complete before the new address goes out.
                    if (redirect) begin
                        r_Redirect <= target;
                    end
                    if (i_IMemAck) begin
                        r_ReqAddr <= redirect ? target : r_Redirect;
                        state     <= ST_REQ;
                    end
                    if (!i_StallF) begin
                        instr_d <= '0;
                        valid_d <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!i_StallF) begin
                        state <= ST_REQ;
                        if (redirect) begin
                            r_ReqAddr <= target;
                            instr_d   <= '0;
                            valid_d   <= 1'b0;
                        end else begin
                            instr_d <= skid_instr;
                            pc4_d   <= skid_pc4;
                            valid_d <= 1'b1;
                        end
                    end
                end
                default: state <= ST_REQ;
            endcase
            // Flush wins over every IF/ID load or hold, stalled or not.
            if (i_FlushD) begin
                instr_d <= '0;
                valid_d <= 1'b0;
            end
        end
    end

    assign o_IMemReq   = (state != ST_HOLD);
    assign o_IMemAddr  = r_ReqAddr;
    assign o_PCF       = r_ReqAddr;
    assign o_InstrD    = instr_d;
    assign o_PCPlus4D  = pc4_d;
    assign o_ValidD    = valid_d;
    assign o_FetchWait = o_IMemReq & ~i_IMemAck;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a transaction-level fetch model feeds a
// scoreboard of expected IF/ID contents, checked as decode consumes them.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DATA_KEY = 32'hA5A5_0000;

    logic        i_CLK = 1'b0;
    logic        i_RST = 1'b0;
    logic        i_StallF = 1'b0;
    logic        i_FlushD = 1'b0;
    logic        i_PCSrcD = 1'b0;
    logic [31:0] i_PCNextD = '0;
    logic        o_IMemReq;
    logic [31:0] o_IMemAddr;
    logic        i_IMemAck = 1'b0;
    logic [31:0] i_IMemRdata = '0;
    logic [31:0] o_PCF;
    logic [31:0] o_InstrD;
    logic [31:0] o_PCPlus4D;
    logic        o_ValidD;
    logic        o_FetchWait;

    fetch_stage #(
        .ADDRESS_WIDTH(32),
        .INSTR_WIDTH(32),
        .RESET_PC(RESET_PC)
    ) dut (
        .i_CLK(i_CLK),
        .i_RST(i_RST),
        .i_StallF(i_StallF),
        .i_FlushD(i_FlushD),
        .i_PCSrcD(i_PCSrcD),
        .i_PCNextD(i_PCNextD),
        .o_IMemReq(o_IMemReq),
        .o_IMemAddr(o_IMemAddr),
        .i_IMemAck(i_IMemAck),
        .i_IMemRdata(i_IMemRdata),
        .o_PCF(o_PCF),
        .o_InstrD(o_InstrD),
        .o_PCPlus4D(o_PCPlus4D),
        .o_ValidD(o_ValidD),
        .o_FetchWait(o_FetchWait)
    );

    always #5 i_CLK = ~i_CLK;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } entry_t;

    entry_t sb[$];
    int errors = 0;
    int checks = 0;
    int pops = 0;

    // memory model state
    bit mem_busy = 0;
    int mem_cnt = 0;
    int mem_lat = 0;
    int fix_lat = 0;

    // fetch model state
    logic [31:0] m_addr = RESET_PC;
    logic [31:0] m_target = '0;
    bit          m_live = 1;
    bit          m_skid = 0;
    logic [31:0] s_instr = '0;
    logic [31:0] s_pc4 = '0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic deliver(input logic [31:0] instr, input logic [31:0] pc4);
        entry_t e;
        e.instr = instr;
        e.pc4 = pc4;
        if (!i_FlushD) sb.push_back(e);
    endtask

    // Reference: an outstanding fetch is killed by any redirect seen while it is
    // in flight; a parked (stalled) fetch is killed by a redirect on release.
    initial begin
        logic r;
        logic [31:0] tgt;
        forever begin
            @(posedge i_CLK or negedge i_RST);
            if (!i_RST) begin
                m_addr = RESET_PC;
                m_live = 1;
                m_skid = 0;
                sb.delete();
            end else begin
                r = i_PCSrcD && !i_StallF;
                tgt = i_PCNextD & 32'hFFFF_FFFC;
                if (!m_skid) begin
                    if (r) begin
                        m_live = 0;
                        m_target = tgt;
                    end
                    if (i_IMemAck) begin
                        if (!m_live) begin
                            m_addr = m_target;
                            m_live = 1;
                        end else if (!i_StallF) begin
                            deliver(i_IMemRdata, m_addr + 32'd4);
                            m_addr = m_addr + 32'd4;
                        end else begin
                            m_skid = 1;
                            s_instr = i_IMemRdata;
                            s_pc4 = m_addr + 32'd4;
                            m_addr = m_addr + 32'd4;
                        end
                    end
                end else if (!i_StallF) begin
                    m_skid = 0;
                    if (r) m_addr = tgt;
                    else deliver(s_instr, s_pc4);
                end
            end
        end
    end

    // Decode-side monitor: an IF/ID instruction leaves when not stalled or flushed.
    initial begin
        entry_t e;
        forever begin
            @(negedge i_CLK);
            #2;
            if (i_RST) begin
                if (o_ValidD && (!i_StallF || i_FlushD)) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL ifid_unexpected: got instr %h pc4 %h expected none", o_InstrD, o_PCPlus4D);
                    end else begin
                        e = sb.pop_front();
                        pops++;
                        check32("ifid_instr", o_InstrD, e.instr);
                        check32("ifid_pc4", o_PCPlus4D, e.pc4);
                    end
                end
                if (!o_ValidD) check32("bubble_instr", o_InstrD, 32'h0);
            end
        end
    end

    task automatic step(input bit stall, input bit pcsrc, input logic [31:0] nxt, input bit flush);
        @(negedge i_CLK);
        i_StallF = stall;
        i_PCSrcD = pcsrc;
        i_PCNextD = nxt;
        i_FlushD = flush;
        if (!i_RST) begin
            mem_busy = 0;
            i_IMemAck = 0;
        end else begin
            if (i_IMemAck) mem_busy = 0;
            else if (mem_busy) mem_cnt++;
            if (o_IMemReq && !mem_busy) begin
                mem_busy = 1;
                mem_cnt = 0;
                mem_lat = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 3));
            end
            i_IMemAck = mem_busy && (mem_cnt == mem_lat);
            i_IMemRdata = o_IMemAddr ^ DATA_KEY;
        end
        #1;
        check1("imem_req", o_IMemReq, !m_skid);
        check32("imem_addr", o_IMemAddr, m_addr);
        check32("pcf", o_PCF, m_addr);
        check1("fetch_wait", o_FetchWait, !m_skid && !i_IMemAck);
    endtask

    task automatic check_reset_values(input string tag);
        check1({tag, "_valid"}, o_ValidD, 1'b0);
        check32({tag, "_instr"}, o_InstrD, 32'h0);
        check32({tag, "_pc4"}, o_PCPlus4D, 32'h0);
        check1({tag, "_req"}, o_IMemReq, 1'b1);
        check32({tag, "_addr"}, o_IMemAddr, RESET_PC);
    endtask

    task automatic check_first_two(input string tag);
        step(0, 0, 32'h0, 0);
        step(0, 0, 32'h0, 0);
        check32({tag, "_instr0"}, o_InstrD, RESET_PC ^ DATA_KEY);
        check32({tag, "_pc4_0"}, o_PCPlus4D, RESET_PC + 32'd4);
        check1({tag, "_valid0"}, o_ValidD, 1'b1);
        step(0, 0, 32'h0, 0);
        check32({tag, "_instr1"}, o_InstrD, (RESET_PC + 32'd4) ^ DATA_KEY);
        check32({tag, "_pc4_1"}, o_PCPlus4D, RESET_PC + 32'd8);
    endtask

    initial begin
        bit found;
        logic [31:0] nxt;
        fix_lat = 0;
        step(0, 0, 32'h0, 0);
        step(0, 0, 32'h0, 0);
        check_reset_values("reset");
        #2 i_RST = 1'b1;
        check_first_two("boot");

        fix_lat = -1;
        for (int i = 0; i < 3000; i++) begin
            nxt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFD : $urandom;
            step($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0, nxt,
                 $urandom_range(0, 11) == 0);
        end

        for (int i = 0; i < 20; i++) step(0, 0, 32'h0, 0);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        checks++;
        if (pops < 100) begin
            errors++;
            $display("FAIL delivered: got %0d expected at least 100", pops);
        end

        // Redirect during a slow fetch, then reset while in DROP.
        fix_lat = 3;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(0, 0, 32'h0, 0);
            if (mem_busy && mem_cnt == 0 && !i_IMemAck) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL slow_fetch_start: got none expected new request within 20 cycles");
        end
        step(0, 1, 32'h0000_0400, 0);
        step(0, 0, 32'h0, 0);
        check1("drop_wait", o_FetchWait, 1'b1);
        #2 i_RST = 1'b0;
        #1 check_reset_values("mid_reset");
        step(0, 0, 32'h0, 0);
        fix_lat = 0;
        #2 i_RST = 1'b1;
        check_first_two("reboot");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline. It produces the decode stage's inputs (o_InstrD, o_PCPlus4D) and consumes the decode stage's redirect (i_PCNextD, i_PCSrcD).
- Owns the PC register, the instruction-memory request/acknowledge handshake, a 1-entry skid buffer for stalls, and the IF/ID pipeline register.
- Handles variable-latency instruction memory, and redirects that arrive while a fetch is outstanding.

Parameters:
- ADDRESS_WIDTH, 32, PC and memory address width.
- INSTR_WIDTH, 32, instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- i_CLK  in  1  clock, rising edge.
- i_RST  in  1  asynchronous, active-low reset.
- i_StallF  in  1  hazard-unit stall; holds the PC and IF/ID.
- i_FlushD  in  1  hazard-unit flush; forces IF/ID to a bubble.
- i_PCSrcD  in  1  decode redirect request; ignored while i_StallF=1.
- i_PCNextD  in  ADDRESS_WIDTH  redirect target from decode.
- o_IMemReq  out  1  instruction-memory request.
- o_IMemAddr  out  ADDRESS_WIDTH  request address, word aligned.
- i_IMemAck  in  1  memory has valid data this cycle.
- i_IMemRdata  in  INSTR_WIDTH  instruction data, valid with ack.
- o_PCF  out  ADDRESS_WIDTH  address currently being fetched (= o_IMemAddr).
- o_InstrD  out  INSTR_WIDTH  IF/ID instruction.
- o_PCPlus4D  out  ADDRESS_WIDTH  IF/ID PC+4.
- o_ValidD  out  1  IF/ID holds a real instruction.
- o_FetchWait  out  1  request outstanding without ack this cycle.

Behaviour:
- Reset (i_RST=0, asynchronous):
  - state=REQ, r_ReqAddr=RESET_PC, r_Redirect=0, skid buffer empty.
  - o_InstrD=0, o_PCPlus4D=0, o_ValidD=0.
  - o_IMemReq=1 during reset; memory must ignore it, and i_IMemAck is ignored.
- Address rules:
  - o_IMemAddr=o_PCF=r_ReqAddr.
  - The address is stable while o_IMemReq=1 and no ack has been seen.
  - Redirect targets are stored with bits[1:0] forced to 00.
  - PC+4 wraps modulo 2^ADDRESS_WIDTH.
- Definitions:
  - Redirect (R) = i_PCSrcD & ~i_StallF.
  - Bubble = o_InstrD<=0 (nop), o_ValidD<=0, o_PCPlus4D unchanged.
- FSM states: REQ, DROP, HOLD.
  - REQ and DROP: o_IMemReq=1.
  - HOLD: o_IMemReq=0.
  - Zero-wait ack (ack in the same cycle the request is first presented) is legal.
- REQ:
  - ack & R: discard data; r_ReqAddr<=i_PCNextD; IF/ID bubble; stay REQ.
  - ~ack & R: r_Redirect<=i_PCNextD; IF/ID bubble; go DROP; the address stays put.
  - ack & ~R & ~i_StallF: IF/ID<={rdata, r_ReqAddr+4, 1}; r_ReqAddr<=r_ReqAddr+4; stay REQ.
  - ack & i_StallF: skid<={rdata, r_ReqAddr+4}; r_ReqAddr<=+4; IF/ID holds; go HOLD.
  - ~ack & ~i_StallF & ~R: IF/ID bubble.
  - ~ack & i_StallF: IF/ID holds.
- DROP:
  - Request stays high at the old address.
  - A further R updates r_Redirect; the latest target wins.
  - On ack: discard data; r_ReqAddr<=r_Redirect (or i_PCNextD if R in the same cycle); go REQ.
  - IF/ID: bubble when ~i_StallF, hold when stalled.
- HOLD:
  - i_StallF=1: everything holds.
  - ~i_StallF & ~R: IF/ID<=skid contents (valid=1); go REQ. The next fetch is presented the following cycle.
  - ~i_StallF & R: discard skid; r_ReqAddr<=i_PCNextD; IF/ID bubble; go REQ.
- i_FlushD:
  - Forces an IF/ID bubble and overrides any load or hold of IF/ID, including during a stall.
  - Does not change the FSM, PC, or skid buffer.
- o_FetchWait = (state==REQ | state==DROP) & ~i_IMemAck.
- Latency: with zero-wait memory and no hazards, one instruction per cycle. An address presented in cycle n appears on o_InstrD after edge n.
- A reset asserted mid-operation (any state, outstanding request) returns to the reset values immediately. Any later ack for the abandoned request must not arrive; the memory is reset from the same i_RST.

Test Plan:
- Reset release, memory acks every cycle with rdata=addr^32'hA5A5_0000 → addresses 0,4,8,… on consecutive cycles; o_InstrD/o_PCPlus4D = (0x A5A5_0000, 4), (0xA5A5_0004, 8), …; o_ValidD=1 from the first edge after the first ack.
- Memory with 3-cycle latency → o_IMemAddr stable for 3 cycles; o_FetchWait=1 for 2 cycles; IF/ID bubbles between instructions (o_InstrD=0, o_ValidD=0).
- i_StallF=1 for 4 cycles coincident with an ack at addr 0x10 → state HOLD, o_IMemReq=0, IF/ID unchanged. On release, o_InstrD=data@0x10, o_PCPlus4D=0x14, and the next request is at 0x14.
- i_PCSrcD=1, i_PCNextD=0x400 while the fetch at 0x20 is un-acked (2 more wait cycles) → addr stays 0x20 until ack; data discarded; next request at 0x400; no instruction from 0x20 reaches IF/ID.
- Redirect to 0x400 in DROP followed by a second redirect to 0x800 before ack → next request at 0x800. i_PCNextD=0x803 with a zero-wait ack → request at 0x800.
- i_FlushD=1 during a stall with IF/ID valid, and i_RST pulsed low mid-wait in DROP → IF/ID goes to bubble. After reset: o_IMemAddr=RESET_PC, o_ValidD=0, state REQ.
